// File: rtl/memory_stage_pkg.sv
// Package pipes: shared pipeline types for the RV64I core plus the MEM-stage
// state enum, store strobe masks and the alignment check.
package pipes;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic   RegWrite;
        logic   MemRead;
        logic   MemWrite;
        logic   mem_unsigned;
        msize_t msize;
    } control_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result;   // ALU result, or address for loads/stores
        logic [63:0] rd2;      // store data
        logic [4:0]  dst;
        control_t    ctl;
    } execute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] result;
        logic [63:0] srcM;     // extended load data, 0 otherwise
        logic [4:0]  dst;
        control_t    ctl;
        logic        stat;     // 1 = misaligned memory access
    } memory_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } mem_state_t;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    function automatic logic [7:0] strobe_mask(input msize_t sz);
        case (sz)
            MSIZE1:  strobe_mask = STRB_B;
            MSIZE2:  strobe_mask = STRB_H;
            MSIZE4:  strobe_mask = STRB_W;
            default: strobe_mask = STRB_D;
        endcase
    endfunction

    function automatic logic misaligned(input msize_t sz, input logic [2:0] a);
        case (sz)
            MSIZE2:  misaligned = a[0];
            MSIZE4:  misaligned = |a[1:0];
            MSIZE8:  misaligned = |a[2:0];
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// mem_align: combinational lane logic for the MEM stage.
//   Store path: byte strobes and store data shifted to the addressed lanes.
//   Load path : extract the addressed lane from the 64-bit read word and
//               zero/sign extend it to 64 bits.
// Ports: size, offset (addr[2:0]), wdata_raw, rdata_raw, is_unsigned in;
//        strobe_lanes, wdata, rdata_ext out.
module mem_align
    import pipes::*;
(
    input  msize_t      size,
    input  logic [2:0]  offset,
    input  logic [63:0] wdata_raw,
    input  logic [63:0] rdata_raw,
    input  logic        is_unsigned,
    output logic [7:0]  strobe_lanes,
    output logic [63:0] wdata,
    output logic [63:0] rdata_ext
);

    logic [5:0]  bit_off;
    logic [63:0] rshift;

    assign bit_off      = {offset, 3'b000};
    assign strobe_lanes = strobe_mask(size) << offset;
    assign wdata        = wdata_raw << bit_off;   // upper bytes fall off the word
    assign rshift       = rdata_raw >> bit_off;

    always_comb begin
        rdata_ext = rshift;
        case (size)
            MSIZE1:  rdata_ext = is_unsigned ? {56'd0, rshift[7:0]}
                                             : {{56{rshift[7]}}, rshift[7:0]};
            MSIZE2:  rdata_ext = is_unsigned ? {48'd0, rshift[15:0]}
                                             : {{48{rshift[15]}}, rshift[15:0]};
            MSIZE4:  rdata_ext = is_unsigned ? {32'd0, rshift[31:0]}
                                             : {{32{rshift[31]}}, rshift[31:0]};
            default: rdata_ext = rshift;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the RV64I pipeline. Registers the EX result,
// runs one data-bus transaction per load/store, and presents memory_data_t
// to write-back with a valid/ready handshake.
// Ports: clk, reset (async, active low); ex_valid/ex_data/ex_ready from EX;
//        mem_valid/mem_data/wb_ready to WB; flush; dreq_* bus request;
//        dresp_data_ok/dresp_data bus response; busy to the hazard unit.
module memory_stage
    import pipes::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  execute_data_t     ex_data,
    output logic              ex_ready,
    output logic              mem_valid,
    output memory_data_t      mem_data,
    input  logic              wb_ready,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output msize_t            dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [63:0]       dreq_data,
    input  logic              dresp_data_ok,
    input  logic [63:0]       dresp_data,
    output logic              busy
);

    mem_state_t    state;
    execute_data_t req;        // instruction owning the bus transaction
    logic [7:0]    lanes;
    logic [63:0]   load_ext;
    logic          ex_is_mem;
    logic          ex_misal;
    logic          accept;

    mem_align u_align (
        .size         (req.ctl.msize),
        .offset       (req.result[2:0]),
        .wdata_raw    (req.rd2),
        .rdata_raw    (dresp_data),
        .is_unsigned  (req.ctl.mem_unsigned),
        .strobe_lanes (lanes),
        .wdata        (dreq_data),
        .rdata_ext    (load_ext)
    );

    assign ex_is_mem = ex_data.ctl.MemRead | ex_data.ctl.MemWrite;
    assign ex_misal  = misaligned(ex_data.ctl.msize, ex_data.result[2:0]);
    assign ex_ready  = ((state == IDLE) | ((state == DONE) & wb_ready)) & ~flush;
    assign accept    = ex_valid & ex_ready;

    // Bus request comes straight from registered state so it is stable for
    // the whole transaction, including the DRAIN of a flushed access.
    assign busy        = (state == REQ) | (state == DRAIN);
    assign dreq_valid  = busy;
    assign dreq_addr   = req.result[ADDR_W-1:0];
    assign dreq_size   = req.ctl.msize;
    assign dreq_strobe = (busy & req.ctl.MemWrite) ? lanes : 8'h00;
    assign mem_valid   = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            req      <= '0;
            mem_data <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (accept) begin
                        if (ex_is_mem && !ex_misal) begin
                            req   <= ex_data;
                            state <= REQ;
                        end else begin
                            mem_data.pc     <= ex_data.pc;
                            mem_data.result <= ex_data.result;
                            mem_data.srcM   <= '0;
                            mem_data.dst    <= ex_data.dst;
                            mem_data.ctl    <= ex_data.ctl;
                            mem_data.stat   <= ex_is_mem & ex_misal;
                            state           <= DONE;
                        end
                    end else if (state == DONE && wb_ready) begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (flush) begin
                        // A response in the flush cycle already ends the bus op.
                        state <= dresp_data_ok ? IDLE : DRAIN;
                    end else if (dresp_data_ok) begin
                        mem_data.pc     <= req.pc;
                        mem_data.result <= req.result;
                        mem_data.srcM   <= req.ctl.MemRead ? load_ext : 64'd0;
                        mem_data.dst    <= req.dst;
                        mem_data.ctl    <= req.ctl;
                        mem_data.stat   <= 1'b0;
                        state           <= DONE;
                    end
                end
                DRAIN: begin
                    if (dresp_data_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenario tasks plus a
// scoreboard of expected write-back records checked at each handshake.
module tb_memory_stage;
    import pipes::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid;
    execute_data_t ex_data;
    logic          ex_ready;
    logic          mem_valid;
    memory_data_t  mem_data;
    logic          wb_ready;
    logic          flush;
    logic          dreq_valid;
    logic [63:0]   dreq_addr;
    msize_t        dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_data_ok;
    logic [63:0]   dresp_data;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    memory_data_t sb[$];

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_data(ex_data),
        .ex_ready(ex_ready), .mem_valid(mem_valid), .mem_data(mem_data),
        .wb_ready(wb_ready), .flush(flush), .dreq_valid(dreq_valid),
        .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .busy(busy)
    );

    function automatic execute_data_t mk_ex(input logic [63:0] pc, input logic [63:0] res,
                                            input logic [63:0] rd2, input logic rd,
                                            input logic wr, input logic uns, input msize_t sz);
        execute_data_t e;
        e.pc = pc; e.result = res; e.rd2 = rd2; e.dst = pc[6:2];
        e.ctl.RegWrite = ~wr; e.ctl.MemRead = rd; e.ctl.MemWrite = wr;
        e.ctl.mem_unsigned = uns; e.ctl.msize = sz;
        return e;
    endfunction

    function automatic memory_data_t mk_exp(input execute_data_t e, input logic [63:0] srcm,
                                            input logic st);
        memory_data_t m;
        m.pc = e.pc; m.result = e.result; m.srcM = srcm; m.dst = e.dst;
        m.ctl = e.ctl; m.stat = st;
        return m;
    endfunction

    task automatic step(); @(posedge clk); #1; endtask
    task automatic smp();  @(negedge clk); endtask

    // Scoreboard: every write-back handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && mem_valid && wb_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got %h, required no output", mem_data);
            end else begin
                memory_data_t e;
                e = sb.pop_front();
                if (mem_data !== e) begin
                    n_fail++;
                    $display("FAIL wb_data: got %h, required %h", mem_data, e);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0; ex_valid = 0; ex_data = '0; wb_ready = 1; flush = 0;
        dresp_data_ok = 0; dresp_data = '0;
        #12;
        n_checks++;
        if ({mem_valid, dreq_valid, busy, dreq_strobe} !== 11'd0 || mem_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: mv=%b dv=%b busy=%b strb=%h md=%h, required all 0",
                     mem_valid, dreq_valid, busy, dreq_strobe, mem_data);
        end
        step(); reset = 1'b1;
        smp();
        n_checks++;
        if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready: got %b, required 1", ex_ready); end
    endtask

    task automatic test_alu_back_to_back();
        execute_data_t e;
        wb_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            e = mk_ex(64'h100 + 64'(4*i), 64'h1234 + 64'(i), 64'h0, 0, 0, 0, MSIZE8);
            ex_valid = 1; ex_data = e;
            sb.push_back(mk_exp(e, 64'h0, 1'b0));
            smp();
            n_checks++;
            if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ex_ready[%0d]: got %b, required 1", i, ex_ready); end
            if (i > 0) begin
                n_checks++;
                if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_mem_valid[%0d]: got %b, required 1", i-1, mem_valid); end
            end
        end
        step(); ex_valid = 0;
        smp();
        n_checks++;
        if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_mem_valid[2]: got %b, required 1", mem_valid); end
        step(); smp();
        n_checks++;
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b, required 0", mem_valid); end
    endtask

    task automatic test_load_lb(input logic uns);
        execute_data_t e;
        wb_ready = 1;
        step();
        e = mk_ex(64'h200, 64'h1003, 64'h0, 1, 0, uns, MSIZE1);
        ex_valid = 1; ex_data = e;
        sb.push_back(mk_exp(e, uns ? 64'h80 : 64'hFFFF_FFFF_FFFF_FF80, 1'b0));
        step(); ex_valid = 0;
        dresp_data_ok = 1; dresp_data = 64'h0000_0000_8000_0000;
        smp();
        n_checks++;
        if (dreq_valid !== 1 || dreq_addr !== 64'h1003 || dreq_strobe !== 8'h00 || dreq_size !== MSIZE1) begin
            n_fail++;
            $display("FAIL lb_req: dv=%b addr=%h strb=%h size=%0d, required 1/1003/00/0",
                     dreq_valid, dreq_addr, dreq_strobe, dreq_size);
        end
        step(); dresp_data_ok = 0; dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        smp();
        n_checks++;
        if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL lb_latency: mem_valid got %b, required 1", mem_valid); end
        step(); smp();
    endtask

    task automatic test_store_sh();
        execute_data_t e;
        wb_ready = 1;
        step();
        e = mk_ex(64'h300, 64'h2006, 64'h1111_0000_0000_ABCD, 0, 1, 0, MSIZE2);
        ex_valid = 1; ex_data = e;
        sb.push_back(mk_exp(e, 64'h0, 1'b0));
        step(); ex_valid = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin dresp_data_ok = 1; dresp_data = 64'h5555_5555_5555_5555; end
            smp();
            n_checks++;
            if (dreq_valid !== 1 || dreq_strobe !== 8'hC0 || dreq_data !== 64'hABCD_0000_0000_0000 ||
                dreq_addr !== 64'h2006 || busy !== 1 || ex_ready !== 0 || mem_valid !== 0) begin
                n_fail++;
                $display("FAIL sh_hold[%0d]: dv=%b strb=%h data=%h addr=%h busy=%b rdy=%b mv=%b, required 1/c0/abcd000000000000/2006/1/0/0",
                         k, dreq_valid, dreq_strobe, dreq_data, dreq_addr, busy, ex_ready, mem_valid);
            end
            step();
        end
        dresp_data_ok = 0;
        smp();
        n_checks++;
        if (mem_valid !== 1 || busy !== 0 || dreq_valid !== 0) begin
            n_fail++;
            $display("FAIL sh_done: mv=%b busy=%b dv=%b, required 1/0/0", mem_valid, busy, dreq_valid);
        end
        step(); smp();
    endtask

    task automatic test_misaligned();
        execute_data_t e;
        memory_data_t  x;
        wb_ready = 0;
        step();
        e = mk_ex(64'h400, 64'h1002, 64'h0, 1, 0, 0, MSIZE4);
        x = mk_exp(e, 64'h0, 1'b1);
        ex_valid = 1; ex_data = e;
        smp();
        n_checks++;
        if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL mis_accept: got %b, required 1", ex_ready); end
        step(); ex_valid = 0;
        for (int k = 0; k < 2; k++) begin
            smp();
            n_checks++;
            if (dreq_valid !== 0 || mem_valid !== 1 || mem_data !== x || ex_ready !== 0) begin
                n_fail++;
                $display("FAIL mis_hold[%0d]: dv=%b mv=%b rdy=%b md=%h, required 0/1/0 %h",
                         k, dreq_valid, mem_valid, ex_ready, mem_data, x);
            end
            step();
        end
        wb_ready = 1;
        sb.push_back(x);
        smp();
        step(); smp();
        n_checks++;
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mis_release: got %b, required 0", mem_valid); end
    endtask

    task automatic test_flush_drain();
        wb_ready = 1;
        // flush beats a simultaneous accept
        step();
        ex_valid = 1; ex_data = mk_ex(64'h500, 64'h77, 64'h0, 0, 0, 0, MSIZE8); flush = 1;
        smp();
        n_checks++;
        if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL flush_prio_rdy: got %b, required 0", ex_ready); end
        step(); flush = 0;
        ex_data = mk_ex(64'h504, 64'h3000, 64'h0, 1, 0, 0, MSIZE8);
        smp();
        n_checks++;
        if (mem_valid !== 0 || busy !== 0) begin n_fail++; $display("FAIL flush_prio_state: mv=%b busy=%b, required 0/0", mem_valid, busy); end
        step(); ex_valid = 0;
        smp();
        n_checks++;
        if (dreq_valid !== 1 || dreq_addr !== 64'h3000) begin n_fail++; $display("FAIL ld_req: dv=%b addr=%h, required 1/3000", dreq_valid, dreq_addr); end
        step(); flush = 1;
        smp();
        step(); flush = 0;
        smp();
        n_checks++;
        if (dreq_valid !== 1 || busy !== 1 || ex_ready !== 0) begin
            n_fail++; $display("FAIL drain_hold: dv=%b busy=%b rdy=%b, required 1/1/0", dreq_valid, busy, ex_ready);
        end
        step(); dresp_data_ok = 1; dresp_data = 64'h1234_5678_9ABC_DEF0;
        smp();
        n_checks++;
        if (dreq_valid !== 1) begin n_fail++; $display("FAIL drain_resp: dv=%b, required 1", dreq_valid); end
        step(); dresp_data_ok = 0;
        smp();
        n_checks++;
        if (ex_ready !== 1 || mem_valid !== 0 || dreq_valid !== 0) begin
            n_fail++; $display("FAIL drain_end: rdy=%b mv=%b dv=%b, required 1/0/0", ex_ready, mem_valid, dreq_valid);
        end
        // stray response while idle must be ignored
        step(); dresp_data_ok = 1;
        smp();
        step(); dresp_data_ok = 0;
        smp();
        n_checks++;
        if (mem_valid !== 0 || busy !== 0) begin n_fail++; $display("FAIL stray_resp: mv=%b busy=%b, required 0/0", mem_valid, busy); end
    endtask

    task automatic test_reset_mid_req();
        wb_ready = 1;
        step();
        ex_valid = 1; ex_data = mk_ex(64'h600, 64'h4000, 64'h0, 1, 0, 0, MSIZE8);
        step(); ex_valid = 0;
        smp();
        n_checks++;
        if (dreq_valid !== 1'b1) begin n_fail++; $display("FAIL rst_req: dv=%b, required 1", dreq_valid); end
        #1 reset = 0;
        #1;
        n_checks++;
        if (dreq_valid !== 0 || mem_valid !== 0 || busy !== 0 || dreq_strobe !== 0 || mem_data !== '0) begin
            n_fail++;
            $display("FAIL rst_async: dv=%b mv=%b busy=%b strb=%h md=%h, required all 0",
                     dreq_valid, mem_valid, busy, dreq_strobe, mem_data);
        end
        step(); reset = 1;
        smp();
        n_checks++;
        if (ex_ready !== 1 || busy !== 0 || dreq_valid !== 0) begin
            n_fail++; $display("FAIL rst_release: rdy=%b busy=%b dv=%b, required 1/0/0", ex_ready, busy, dreq_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_load_lb(1'b0);
        test_load_lb(1'b1);
        test_store_sh();
        test_misaligned();
        test_flush_drain();
        test_reset_mid_req();
        step(); step();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d entries left, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
